// File: rtl/tour_length_eval.sv
// Closed-tour Manhattan length evaluator with permutation check and best tracking.
// Works on a private snapshot of path[] taken on the accepting edge.
module tour_length_eval #(
    parameter int N = 64,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] xs   [N-1:0],
    input  logic [W-1:0] ys   [N-1:0],
    input  logic [W-1:0] path [N-1:0],
    output logic         busy,
    output logic         done,
    output logic [W-1:0] length,
    output logic         overflow,
    output logic         perm_error,
    output logic [W-1:0] best_length,
    output logic         improved
);
    localparam int IW = $clog2(N);
    localparam logic [W-1:0] NW = W'(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d, i_nxt;
    logic          drain_q, drain_d;
    logic          accept;

    logic [W-1:0]  snap_q [N-1:0];
    logic [N-1:0]  visited_q;
    logic [W-1:0]  ea, eb;
    logic          ea_ok;
    logic [IW-1:0] ca, cb;

    logic [W-1:0]  xa_q, ya_q, xb_q, yb_q;
    logic [W-1:0]  dx, dy;
    logic          v1_q, v2_q;
    logic [W:0]    term_q, acc_q;
    logic [W+1:0]  sum;
    logic          sat;

    logic          busy_q, done_q, ovf_q, perm_q, imp_q;
    logic [W-1:0]  len_q, best_q;

    // Out-of-range entries read the coordinates of city 0.
    function automatic logic [IW-1:0] city(input logic [W-1:0] e);
        return (e < NW) ? e[IW-1:0] : '0;
    endfunction

    assign i_nxt = (i_q == LAST) ? '0 : i_q + IW'(1);
    assign ea    = snap_q[i_q];
    assign eb    = snap_q[i_nxt];
    assign ea_ok = ea < NW;
    assign ca    = city(ea);
    assign cb    = city(eb);

    assign dx  = (xa_q >= xb_q) ? xa_q - xb_q : xb_q - xa_q;
    assign dy  = (ya_q >= yb_q) ? ya_q - yb_q : yb_q - ya_q;
    assign sum = {1'b0, acc_q} + {1'b0, term_q};
    assign sat = |sum[W+1:W];

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        drain_d = drain_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    i_d     = '0;
                end
            end
            RUN: begin
                i_d = i_nxt;
                if (i_q == LAST) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = FINISH;
            end
            FINISH: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) snap_q <= path;
        xa_q   <= xs[ca];
        ya_q   <= ys[ca];
        xb_q   <= xs[cb];
        yb_q   <= ys[cb];
        term_q <= {1'b0, dx} + {1'b0, dy};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            drain_q   <= 1'b0;
            visited_q <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            perm_q    <= 1'b0;
            best_q    <= '1;
            imp_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            drain_q <= drain_d;
            v1_q    <= (state_q == RUN);
            v2_q    <= v1_q;
            done_q  <= 1'b0;
            imp_q   <= 1'b0;
            if (accept) begin
                acc_q     <= '0;
                visited_q <= '0;
                ovf_q     <= 1'b0;
                perm_q    <= 1'b0;
                busy_q    <= 1'b1;
            end
            if (state_q == RUN) begin
                if (!ea_ok || visited_q[ca]) perm_q <= 1'b1;
                else visited_q[ca] <= 1'b1;
            end
            if (v2_q) begin
                if (sat) begin
                    acc_q <= {1'b0, {W{1'b1}}};
                    ovf_q <= 1'b1;
                end else begin
                    acc_q <= sum[W:0];
                end
            end
            if (state_q == FINISH) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                len_q  <= acc_q[W-1:0];
                if (!perm_q && !ovf_q && acc_q[W-1:0] < best_q) begin
                    best_q <= acc_q[W-1:0];
                    imp_q  <= 1'b1;
                end
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign length      = len_q;
    assign overflow    = ovf_q;
    assign perm_error  = perm_q;
    assign best_length = best_q;
    assign improved    = imp_q;
endmodule

// File: tb/tb_tour_length_eval.sv
// Bench for tour_length_eval: vector table, corner sequences, randomized runs vs model.
module tb_tour_length_eval;
    localparam int N = 4;

    typedef logic [N-1:0][31:0] arr_t;

    typedef struct packed {
        arr_t        p;
        logic [63:0] len;
        logic        perm;
        logic        imp;
        logic [63:0] best;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start8 = 1'b0;

    logic [31:0] xs [N-1:0];
    logic [31:0] ys [N-1:0];
    logic [31:0] path [N-1:0];
    logic [7:0]  xs8 [N-1:0];
    logic [7:0]  ys8 [N-1:0];
    logic [7:0]  path8 [N-1:0];

    logic        busy, done, ovf, perr, imp;
    logic [31:0] len, best;
    logic        busy8, done8, ovf8, perr8, imp8;
    logic [7:0]  len8, best8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tour_length_eval #(.N(N), .W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .xs(xs), .ys(ys), .path(path),
        .busy(busy), .done(done), .length(len),
        .overflow(ovf), .perm_error(perr),
        .best_length(best), .improved(imp)
    );

    tour_length_eval #(.N(N), .W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .xs(xs8), .ys(ys8), .path(path8),
        .busy(busy8), .done(done8), .length(len8),
        .overflow(ovf8), .perm_error(perr8),
        .best_length(best8), .improved(imp8)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic arr_t mk(input int a0, input int a1,
                                input int a2, input int a3);
        arr_t r;
        r[0] = 32'(a0);
        r[1] = 32'(a1);
        r[2] = 32'(a2);
        r[3] = 32'(a3);
        return r;
    endfunction

    function automatic longint absd(input logic [31:0] a, input logic [31:0] b);
        longint la = longint'(a);
        longint lb = longint'(b);
        return (la > lb) ? la - lb : lb - la;
    endfunction

    // Reference: occurrence counting for the permutation test, saturation as min().
    function automatic void model(input arr_t x, input arr_t y, input arr_t p,
                                  input int w, output logic [63:0] l,
                                  output bit o, output bit pe);
        int cnt [N];
        longint total = 0;
        longint lim;
        int a, b;
        pe = 0;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        for (int k = 0; k < N; k++)
            if (p[k] >= N) pe = 1;
            else cnt[p[k]]++;
        for (int k = 0; k < N; k++)
            if (cnt[k] != 1) pe = 1;
        for (int k = 0; k < N; k++) begin
            a = (p[k] < N) ? int'(p[k]) : 0;
            b = (p[(k + 1) % N] < N) ? int'(p[(k + 1) % N]) : 0;
            total += absd(x[a], x[b]) + absd(y[a], y[b]);
        end
        lim = longint'(1) << w;
        o = total >= lim;
        l = o ? 64'(lim - 1) : 64'(total);
    endfunction

    task automatic set32(input arr_t x, input arr_t y, input arr_t p);
        for (int k = 0; k < N; k++) begin
            xs[k]   = x[k];
            ys[k]   = y[k];
            path[k] = p[k];
        end
    endtask

    task automatic set8(input arr_t x, input arr_t y, input arr_t p);
        for (int k = 0; k < N; k++) begin
            xs8[k]   = x[k][7:0];
            ys8[k]   = y[k][7:0];
            path8[k] = p[k][7:0];
        end
    endtask

    // Pulse start, then require done exactly N+3 edges later with busy high until then.
    task automatic run_tour(input bit sel, input string nm);
        int lat;
        bit bok;
        @(negedge clk);
        if (sel) start8 = 1'b1;
        else start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start8 = 1'b0;
        bok = sel ? busy8 : busy;
        lat = 0;
        while (!(sel ? done8 : done) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (!(sel ? done8 : done) && !(sel ? busy8 : busy)) bok = 0;
        end
        if ((sel ? busy8 : busy) !== 1'b0) bok = 0;
        check({nm, " latency"}, 64'(lat), 64'(N + 3));
        check({nm, " busy"}, 64'(bok), 64'd1);
    endtask

    arr_t sqx, sqy;
    vec_t vt [6];

    initial begin
        logic [63:0] ml;
        bit mo, mp, ei;
        logic [63:0] mbest;
        arr_t rx, ry, rp;
        int cyc, seen, tmp, j;

        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] ml;
        bit mo, mp, ei;
        logic [63:0] mbest;
        arr_t rx, ry, rp;
        int cyc, seen, tmp, j, mode;

        sqx = mk(0, 10, 10, 0);
        sqy = mk(0, 0, 10, 10);
        vt[0] = '{p: mk(0, 1, 2, 3), len: 40, perm: 0, imp: 1, best: 40};
        vt[1] = '{p: mk(0, 2, 1, 3), len: 60, perm: 0, imp: 0, best: 40};
        vt[2] = '{p: mk(3, 2, 1, 0), len: 40, perm: 0, imp: 0, best: 40};
        vt[3] = '{p: mk(0, 1, 1, 3), len: 40, perm: 1, imp: 0, best: 40};
        vt[4] = '{p: mk(0, 1, 5, 3), len: 40, perm: 1, imp: 0, best: 40};
        vt[5] = '{p: mk(1, 0, 3, 2), len: 40, perm: 0, imp: 0, best: 40};

        set32(sqx, sqy, mk(0, 1, 2, 3));
        set8(sqx, sqy, mk(0, 1, 2, 3));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst busy", 64'(busy), 0);
        check("rst done", 64'(done), 0);
        check("rst length", 64'(len), 0);
        check("rst overflow", 64'(ovf), 0);
        check("rst perm", 64'(perr), 0);
        check("rst improved", 64'(imp), 0);
        check("rst best", 64'(best), 64'hFFFF_FFFF);
        check("rst best8", 64'(best8), 64'hFF);

        for (int v = 0; v < 6; v++) begin
            set32(sqx, sqy, vt[v].p);
            run_tour(0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d length", v), 64'(len), vt[v].len);
            check($sformatf("vec%0d perm", v), 64'(perr), 64'(vt[v].perm));
            check($sformatf("vec%0d overflow", v), 64'(ovf), 0);
            check($sformatf("vec%0d improved", v), 64'(imp), 64'(vt[v].imp));
            check($sformatf("vec%0d best", v), 64'(best), vt[v].best);
        end

        // start held high; path edited after acceptance must not matter
        set32(sqx, sqy, mk(0, 1, 2, 3));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        set32(sqx, sqy, mk(0, 2, 1, 3));
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("hold done1", 64'(done), 1);
        check("hold len1", 64'(len), 40);
        @(posedge clk);
        #1;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("hold done2", 64'(done), 1);
        check("hold len2", 64'(len), 60);
        check("hold imp2", 64'(imp), 0);

        mbest = 40;
        for (int r = 0; r < 40; r++) begin
            mode = $urandom_range(0, 2);
            for (int k = 0; k < N; k++) begin
                if (mode == 0) begin
                    rx[k] = 32'($urandom_range(0, 20));
                    ry[k] = 32'($urandom_range(0, 20));
                end else if (mode == 1) begin
                    rx[k] = 32'($urandom_range(0, 1000));
                    ry[k] = 32'($urandom_range(0, 1000));
                end else begin
                    rx[k] = $urandom;
                    ry[k] = $urandom;
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < N; k++) rp[k] = 32'(k);
                for (int k = N - 1; k > 0; k--) begin
                    j = $urandom_range(0, k);
                    tmp = int'(rp[k]);
                    rp[k] = rp[j];
                    rp[j] = 32'(tmp);
                end
            end else begin
                for (int k = 0; k < N; k++) rp[k] = 32'($urandom_range(0, 5));
            end
            set32(rx, ry, rp);
            model(rx, ry, rp, 32, ml, mo, mp);
            ei = !mp && !mo && (ml < mbest);
            if (ei) mbest = ml;
            run_tour(0, $sformatf("rnd%0d", r));
            check($sformatf("rnd%0d length", r), 64'(len), ml);
            check($sformatf("rnd%0d overflow", r), 64'(ovf), 64'(mo));
            check($sformatf("rnd%0d perm", r), 64'(perr), 64'(mp));
            check($sformatf("rnd%0d improved", r), 64'(imp), 64'(ei));
            check($sformatf("rnd%0d best", r), 64'(best), mbest);
        end

        // reset in the middle of a run
        set32(sqx, sqy, mk(0, 1, 2, 3));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst busy", 64'(busy), 0);
        check("midrst done", 64'(done), 0);
        check("midrst length", 64'(len), 0);
        check("midrst best", 64'(best), 64'hFFFF_FFFF);
        seen = 0;
        repeat (N + 5) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        check("midrst no done", 64'(seen), 0);
        run_tour(0, "after rst");
        check("after rst length", 64'(len), 40);
        check("after rst improved", 64'(imp), 1);
        check("after rst best", 64'(best), 40);

        // W=8 saturation boundaries
        set8(mk(0, 128, 128, 0), mk(0, 0, 0, 0), mk(0, 1, 2, 3));
        run_tour(1, "w8 256");
        check("w8 256 overflow", 64'(ovf8), 1);
        check("w8 256 length", 64'(len8), 255);
        check("w8 256 improved", 64'(imp8), 0);
        check("w8 256 best", 64'(best8), 255);
        set8(mk(0, 255, 0, 255), mk(0, 255, 0, 255), mk(0, 1, 2, 3));
        run_tour(1, "w8 big");
        check("w8 big overflow", 64'(ovf8), 1);
        check("w8 big length", 64'(len8), 255);
        check("w8 big best", 64'(best8), 255);
        set8(mk(0, 127, 127, 0), mk(0, 0, 0, 0), mk(0, 1, 2, 3));
        run_tour(1, "w8 254");
        check("w8 254 overflow", 64'(ovf8), 0);
        check("w8 254 length", 64'(len8), 254);
        check("w8 254 improved", 64'(imp8), 1);
        check("w8 254 best", 64'(best8), 254);
        run_tour(1, "w8 254b");
        check("w8 254b improved", 64'(imp8), 0);
        check("w8 254b best", 64'(best8), 254);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
